// File: rtl/counter_pkg.sv
// Shared defaults and helpers for the counter bank.
package counter_pkg;

  localparam int NCH_DEF        = 4;
  localparam int W_DEF          = 16;
  localparam int DEF_MOD_DEF    = 64;
  localparam int CASCADE_DEF    = 0;
  localparam int IS_NEGEDGE_DEF = 0;

  // Bits needed to address n entries, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// One modulo counter channel with an active modulus and a one-deep pending modulus.
module counter_chan
  import counter_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int DEF_MOD    = DEF_MOD_DEF,
  parameter int IS_NEGEDGE = IS_NEGEDGE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] cnt,
  output logic         co,
  output logic         tc,
  output logic         pend
);

  logic [W-1:0] m;
  logic [W-1:0] pm;
  logic [W-1:0] cnt_n;
  logic [W-1:0] m_n;
  logic [W-1:0] pm_n;
  logic         pend_n;
  logic         div1;
  logic         at_top;

  // tc is the enable-independent terminal condition; clr masks it except for divide-by-1.
  always_comb begin
    div1   = (m <= W'(1));
    at_top = (cnt == (m - W'(1)));
    tc     = div1 | (~clr & at_top);
    co     = e & tc;
  end

  // Pending modulus moves to active only at a wrap or clear, so a period is never cut short.
  always_comb begin
    cnt_n  = cnt;
    m_n    = m;
    pm_n   = pm;
    pend_n = pend;
    if (clr || co) begin
      cnt_n = '0;
      if (pend) begin
        m_n    = pm;
        pend_n = 1'b0;
      end
    end else if (e) begin
      cnt_n = cnt + W'(1);
    end
    if (wr) begin
      pm_n   = wdata;
      pend_n = 1'b1;
    end
  end

  generate
    if (IS_NEGEDGE != 0) begin : g_neg
      always_ff @(negedge clk) begin
        if (!rst_n) begin
          cnt  <= '0;
          m    <= W'(DEF_MOD);
          pend <= 1'b0;
        end else begin
          cnt  <= cnt_n;
          m    <= m_n;
          pend <= pend_n;
        end
        pm <= pm_n;
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt  <= '0;
          m    <= W'(DEF_MOD);
          pend <= 1'b0;
        end else begin
          cnt  <= cnt_n;
          m    <= m_n;
          pend <= pend_n;
        end
        pm <= pm_n;
      end
    end
  endgenerate

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH modulo counters with optional cascade chaining and a shared modulus write port.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int W          = W_DEF,
  parameter int DEF_MOD    = DEF_MOD_DEF,
  parameter int CASCADE    = CASCADE_DEF,
  parameter int IS_NEGEDGE = IS_NEGEDGE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          mod_valid,
  output logic                          mod_ready,
  input  logic [clog2_min1(NCH)-1:0]    mod_ch,
  input  logic [W-1:0]                  mod_data,
  output logic [NCH*W-1:0]              cnt,
  output logic [NCH-1:0]                co
);

  localparam int CHW   = clog2_min1(NCH);
  localparam int NSLOT = 1 << CHW;

  logic [NCH-1:0]   e;
  logic [NCH-1:0]   tc;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   wr;
  logic [NSLOT-1:0] pend_slot;

  // Unused channel addresses read as never-pending, so they always report ready.
  always_comb begin
    pend_slot           = '0;
    pend_slot[NCH-1:0]  = pend;
    mod_ready           = ~pend_slot[mod_ch];
  end

  // Cascade enable is en ANDed with every lower channel's terminal condition,
  // which equals co[k-1] without routing co back into the enable chain.
  always_comb begin
    logic run;
    run = en;
    e   = '0;
    for (int k = 0; k < NCH; k++) begin
      e[k] = (CASCADE != 0) ? run : en;
      run  = run & tc[k];
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign wr[k] = mod_valid & mod_ready & (mod_ch == CHW'(k));

      counter_chan #(
        .W          (W),
        .DEF_MOD    (DEF_MOD),
        .IS_NEGEDGE (IS_NEGEDGE)
      ) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e[k]),
        .clr   (clr),
        .wr    (wr[k]),
        .wdata (mod_data),
        .cnt   (cnt[k*W +: W]),
        .co    (co[k]),
        .tc    (tc[k]),
        .pend  (pend[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: default, cascaded (NCH=3) and falling-edge instances share stimulus.
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        mod_valid = 1'b0;
  logic [1:0]  mod_ch = 2'd0;
  logic [15:0] mod_data = 16'd0;

  logic        rdy_a, rdy_c, rdy_n;
  logic [63:0] cnt_a, cnt_n;
  logic [47:0] cnt_c;
  logic [3:0]  co_a, co_n;
  logic [2:0]  co_c;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_bank dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mod_valid(mod_valid),
    .mod_ready(rdy_a), .mod_ch(mod_ch), .mod_data(mod_data), .cnt(cnt_a), .co(co_a)
  );

  counter_bank #(.NCH(3), .CASCADE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mod_valid(mod_valid),
    .mod_ready(rdy_c), .mod_ch(mod_ch), .mod_data(mod_data), .cnt(cnt_c), .co(co_c)
  );

  counter_bank #(.IS_NEGEDGE(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mod_valid(mod_valid),
    .mod_ready(rdy_n), .mod_ch(mod_ch), .mod_data(mod_data), .cnt(cnt_n), .co(co_n)
  );

  // One active edge for both the rising- and falling-edge instances.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mod_valid = 1'b0; mod_ch = 2'd0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b1; mod_valid = 1'b1; mod_ch = 2'd0; mod_data = 16'd3;
    tick();
    rst_n = 1'b1; clr = 1'b0; mod_valid = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 64'd0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", cnt_a); end
    n_cmp++; if (co_a !== 4'd0) begin n_fail++; $display("FAIL reset_co: got %b expected 0000", co_a); end
    n_cmp++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rdy_a); end
    n_cmp++; if (cnt_n !== 64'd0) begin n_fail++; $display("FAIL reset_cnt_neg: got %h expected 0", cnt_n); end
  endtask

  task automatic test_period();
    int first, second, np;
    first = 0; second = 0; np = 0;
    rst_n = 1'b0; en = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      #1;
      if (co_a[0]) begin
        np++;
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
      tick();
    end
    n_cmp++; if (first !== 64) begin n_fail++; $display("FAIL period_first: got %0d expected 64", first); end
    n_cmp++; if (second !== 128) begin n_fail++; $display("FAIL period_second: got %0d expected 128", second); end
    n_cmp++; if (np !== 2) begin n_fail++; $display("FAIL period_count: got %0d expected 2", np); end
  endtask

  task automatic test_mod_write();
    do_reset();
    en = 1'b1;
    repeat (10) tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd10) begin n_fail++; $display("FAIL mw_cnt10: got %0d expected 10", cnt_a[15:0]); end
    mod_valid = 1'b1; mod_ch = 2'd0; mod_data = 16'd5;
    #1;
    n_cmp++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL mw_ready_pre: got %b expected 1", rdy_a); end
    tick();
    mod_valid = 1'b0;
    #1;
    n_cmp++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL mw_ready_busy: got %b expected 0", rdy_a); end
    repeat (52) tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd63) begin n_fail++; $display("FAIL mw_cnt63: got %0d expected 63", cnt_a[15:0]); end
    n_cmp++; if (co_a[0] !== 1'b1) begin n_fail++; $display("FAIL mw_co63: got %b expected 1", co_a[0]); end
    n_cmp++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL mw_ready_63: got %b expected 0", rdy_a); end
    tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd0) begin n_fail++; $display("FAIL mw_wrap: got %0d expected 0", cnt_a[15:0]); end
    n_cmp++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL mw_ready_post: got %b expected 1", rdy_a); end
    repeat (4) tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd4 || co_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL mw_cnt4: got cnt %0d co %b expected cnt 4 co 1", cnt_a[15:0], co_a[0]);
    end
    tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd0) begin n_fail++; $display("FAIL mw_wrap5: got %0d expected 0", cnt_a[15:0]); end
    n_cmp++; if (cnt_a[31:16] !== 16'd5) begin n_fail++; $display("FAIL mw_ch1: got %0d expected 5", cnt_a[31:16]); end
  endtask

  task automatic test_cascade();
    int first, np, bad;
    first = 0; np = 0; bad = 0;
    do_reset();
    mod_valid = 1'b1; mod_ch = 2'd0; mod_data = 16'd4;
    tick();
    mod_ch = 2'd1; mod_data = 16'd3;
    tick();
    mod_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      #1;
      if (co_c[1]) begin
        np++;
        if (first == 0) first = i;
        if (!co_c[0]) bad++;
      end
      tick();
    end
    n_cmp++; if (first !== 12) begin n_fail++; $display("FAIL casc_first: got %0d expected 12", first); end
    n_cmp++; if (np !== 2) begin n_fail++; $display("FAIL casc_count: got %0d expected 2", np); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL casc_coincide: got %0d expected 0", bad); end
    n_cmp++; if (cnt_c[47:32] !== 16'd2) begin n_fail++; $display("FAIL casc_ch2: got %0d expected 2", cnt_c[47:32]); end
  endtask

  task automatic test_div1();
    do_reset();
    mod_valid = 1'b1; mod_ch = 2'd2; mod_data = 16'd1;
    tick();
    mod_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = i[0];
      #1;
      n_cmp++; if (co_a[2] !== en || cnt_a[47:32] !== 16'd0) begin
        n_fail++; $display("FAIL div1_step%0d: got co %b cnt %0d expected co %b cnt 0", i, co_a[2], cnt_a[47:32], en);
      end
      tick();
    end
    en = 1'b1; clr = 1'b1;
    #1;
    n_cmp++; if (co_a[2] !== 1'b1 || co_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL div1_clr: got co2 %b co0 %b expected 1 0", co_a[2], co_a[0]);
    end
    tick();
    clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_write_block();
    do_reset();
    mod_valid = 1'b1; mod_ch = 2'd1; mod_data = 16'd9;
    tick();
    mod_data = 16'd20;
    #1;
    n_cmp++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL blk_ready: got %b expected 0", rdy_a); end
    tick();
    mod_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    repeat (8) tick();
    n_cmp++; if (cnt_a[31:16] !== 16'd8 || co_a[1] !== 1'b1) begin
      n_fail++; $display("FAIL blk_m9: got cnt %0d co %b expected cnt 8 co 1", cnt_a[31:16], co_a[1]);
    end
    tick();
    en = 1'b0;
    // Channel address 3 does not exist on the three-channel instance.
    do_reset();
    mod_ch = 2'd3; mod_valid = 1'b1; mod_data = 16'd2;
    #1;
    n_cmp++; if (rdy_c !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", rdy_c); end
    tick();
    mod_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mod_ch = k[1:0];
      #1;
      n_cmp++; if (rdy_c !== 1'b1) begin n_fail++; $display("FAIL oor_ch%0d_ready: got %b expected 1", k, rdy_c); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    #4;
    n_cmp++; if (cnt_n[15:0] !== 16'd1 || cnt_a[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL neg_edge_timing: got neg %0d pos %0d expected 1 0", cnt_n[15:0], cnt_a[15:0]);
    end
    #1;
    repeat (30) tick();
    mod_valid = 1'b1; mod_ch = 2'd0; mod_data = 16'd5;
    tick();
    mod_valid = 1'b0;
    #1;
    n_cmp++; if (cnt_a[15:0] !== 16'd31 || cnt_n[15:0] !== 16'd31) begin
      n_fail++; $display("FAIL rm_cnt31: got pos %0d neg %0d expected 31", cnt_a[15:0], cnt_n[15:0]);
    end
    n_cmp++; if (rdy_a !== 1'b0 || rdy_n !== 1'b0) begin
      n_fail++; $display("FAIL rm_pending: got pos %b neg %b expected 0", rdy_a, rdy_n);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (cnt_a[15:0] !== 16'd0 || cnt_n[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL rm_cnt0: got pos %0d neg %0d expected 0", cnt_a[15:0], cnt_n[15:0]);
    end
    n_cmp++; if (rdy_a !== 1'b1 || rdy_n !== 1'b1) begin
      n_fail++; $display("FAIL rm_ready: got pos %b neg %b expected 1", rdy_a, rdy_n);
    end
    repeat (63) tick();
    n_cmp++; if (cnt_a[15:0] !== 16'd63 || cnt_n[15:0] !== 16'd63) begin
      n_fail++; $display("FAIL rm_defmod: got pos %0d neg %0d expected 63", cnt_a[15:0], cnt_n[15:0]);
    end
    n_cmp++; if (co_a[0] !== 1'b1 || co_n[0] !== 1'b1) begin
      n_fail++; $display("FAIL rm_co: got pos %b neg %b expected 1", co_a[0], co_n[0]);
    end
    en = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_period();
    test_mod_write();
    test_cascade();
    test_div1();
    test_write_block();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
